// File: rtl/airlock_pkg.sv
// Shared types and defaults for the airlock request arbiter.
package airlock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CYCLE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 10;
  localparam int DEF_CYCLE_TICKS = 7;
  localparam int CH_ARRIVE       = 0;
  localparam int CH_DEPART       = 1;

endpackage

// File: rtl/airlock_sync_edge.sv
// Synchroniser chain for one raw switch plus rising-edge detect on its output.
module airlock_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Shift the switch through the chain and keep the last stage for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/airlock_cycle_arbiter.sv
// Round-robin arbiter that runs one timed pressure cycle per pending request.
module airlock_cycle_arbiter
  import airlock_pkg::*;
#(
  parameter int CH          = 2,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    req_sw,
  input  logic             tick,
  input  logic             abort,
  output logic [CH-1:0]    pending,
  output logic [CH-1:0]    grant,
  output logic             busy,
  output logic [CH-1:0]    done,
  output logic [CNT_W-1:0] remaining
);

  localparam int PTR_W = (CH > 1) ? $clog2(CH) : 1;

  state_t            state_r, state_nxt_s;
  logic [CH-1:0]     pending_r, pending_nxt_s;
  logic [CH-1:0]     grant_r, grant_nxt_s;
  logic [CH-1:0]     done_r, done_nxt_s;
  logic [CH-1:0]     rise_s, pick_s, clear_s, block_s;
  logic [2*CH-1:0]   rot_s;
  logic [CNT_W-1:0]  remaining_r, remaining_nxt_s;
  logic [PTR_W-1:0]  rr_ptr_r, rr_ptr_nxt_s, gidx_s, ptr_wrap_s;
  logic              busy_r, busy_nxt_s;

  for (genvar i = 0; i < CH; i++) begin : g_sync
    airlock_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (req_sw[i]),
      .rise (rise_s[i])
    );
  end

  // Round-robin pick: rotate pending so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    int  sel;
    logic found;
    sel    = 0;
    found  = 1'b0;
    pick_s = {CH{1'b0}};
    rot_s  = {pending_r, pending_r} >> rr_ptr_r;
    for (int i = 0; i < CH; i++) begin
      if (!found && rot_s[i]) begin
        sel   = (int'(rr_ptr_r) + i) % CH;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    for (int i = 0; i < CH; i++) begin
      pick_s[i] = found && (sel == i);
    end
  end

  // Index of the granted channel and the pointer value just past it.
  always_comb begin
    gidx_s = {PTR_W{1'b0}};
    for (int i = 0; i < CH; i++) begin
      if (grant_r[i]) begin
        gidx_s = PTR_W'(i);
      end else begin
        gidx_s = gidx_s;
      end
    end
    ptr_wrap_s = (gidx_s == PTR_W'(CH - 1)) ? {PTR_W{1'b0}} : gidx_s + PTR_W'(1);
  end

  // Next-state and next-output logic for the cycle FSM.
  always_comb begin
    state_nxt_s     = state_r;
    grant_nxt_s     = grant_r;
    remaining_nxt_s = remaining_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    done_nxt_s      = {CH{1'b0}};
    clear_s         = {CH{1'b0}};
    case (state_r)
      IDLE: begin
        if (!abort && (|pending_r)) begin
          grant_nxt_s     = pick_s;
          remaining_nxt_s = CNT_W'(CYCLE_TICKS);
          state_nxt_s     = CYCLE;
        end else begin
          grant_nxt_s     = {CH{1'b0}};
          remaining_nxt_s = {CNT_W{1'b0}};
        end
      end
      CYCLE: begin
        if (abort) begin
          grant_nxt_s     = {CH{1'b0}};
          remaining_nxt_s = {CNT_W{1'b0}};
          state_nxt_s     = IDLE;
        end else if (tick) begin
          remaining_nxt_s = (remaining_r != {CNT_W{1'b0}}) ? remaining_r - CNT_W'(1)
                                                            : {CNT_W{1'b0}};
          if (remaining_r == CNT_W'(1)) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CYCLE;
          end
        end else begin
          state_nxt_s = CYCLE;
        end
      end
      DONE: begin
        done_nxt_s      = grant_r;
        clear_s         = grant_r;
        grant_nxt_s     = {CH{1'b0}};
        remaining_nxt_s = {CNT_W{1'b0}};
        rr_ptr_nxt_s    = ptr_wrap_s;
        state_nxt_s     = IDLE;
      end
      default: begin
        grant_nxt_s     = {CH{1'b0}};
        remaining_nxt_s = {CNT_W{1'b0}};
        state_nxt_s     = IDLE;
      end
    endcase

    // Edges on the channel being cycled are dropped; the completion clear wins.
    block_s       = (state_r == IDLE) ? {CH{1'b0}} : grant_r;
    pending_nxt_s = (pending_r | (rise_s & ~block_s)) & ~clear_s;
    busy_nxt_s    = (state_nxt_s == CYCLE) || (state_nxt_s == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      pending_r   <= {CH{1'b0}};
      grant_r     <= {CH{1'b0}};
      done_r      <= {CH{1'b0}};
      remaining_r <= {CNT_W{1'b0}};
      rr_ptr_r    <= {PTR_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pending_r   <= pending_nxt_s;
      grant_r     <= grant_nxt_s;
      done_r      <= done_nxt_s;
      remaining_r <= remaining_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign pending   = pending_r;
  assign grant     = grant_r;
  assign done      = done_r;
  assign remaining = remaining_r;
  assign busy      = busy_r;

endmodule
